// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer in front of a word-wide DataMemory.
// Sizes accesses, formats loads, and does read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned RD_LAT = 4,
  parameter int unsigned WR_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_RD,
    S_MERGE,
    S_WR,
    S_DONE
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_we;
  logic [2:0]         r_f3;
  logic [1:0]         r_lo;
  logic [15:0]        r_wd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_resp_valid;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_mis;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;

  logic               w_illegal;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;
  logic [31:0]        w_merged;

  // Gated with rst so the pipeline never sees ready while reset is asserted.
  assign req_ready       = r_ready & ~rst;
  assign resp_valid      = r_resp_valid;
  assign resp_rdata      = r_resp_rdata;
  assign resp_misaligned = r_resp_mis;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;

  // Misaligned, illegal size code, or unsigned store variant.
  always_comb begin
    w_illegal = 1'b0;
    case (req_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = req_addr[0];
      3'b010:  w_illegal = |req_addr[1:0];
      3'b100:  w_illegal = req_we;
      3'b101:  w_illegal = req_we | req_addr[0];
      default: w_illegal = 1'b1;
    endcase
  end

  // Little-endian lane select plus sign/zero extension of the read word.
  always_comb begin
    w_byte = 8'(mem_rdata >> {r_lo, 3'b000});
    w_half = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h000000, w_byte};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Replace the addressed lane of the read word with the store data.
  always_comb begin
    w_merged = mem_rdata;
    if (r_f3[0]) begin
      w_merged[{r_lo[1], 4'b0000} +: 16] = r_wd;
    end else begin
      w_merged[{r_lo, 3'b000} +: 8] = r_wd[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_we         <= 1'b0;
      r_f3         <= 3'b000;
      r_lo         <= 2'b00;
      r_wd         <= 16'h0000;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_mis   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && req_valid) begin
            r_ready <= 1'b0;
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_lo    <= req_addr[1:0];
            r_wd    <= req_wdata[15:0];
            r_cnt   <= '0;
            if (w_illegal) begin
              r_state      <= S_ERR;
              r_resp_valid <= 1'b1;
              r_resp_mis   <= 1'b1;
            end else begin
              r_mem_addr <= {req_addr[31:2], 2'b00};
              if (req_we && req_funct3 == 3'b010) begin
                r_state     <= S_WR;
                r_mem_write <= 1'b1;
                r_mem_wdata <= req_wdata;
              end else begin
                r_state    <= S_RD;
                r_mem_read <= 1'b1;
              end
            end
          end
        end
        S_ERR: begin
          r_resp_valid <= 1'b0;
          r_resp_mis   <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= S_IDLE;
        end
        S_RD: begin
          if (r_cnt == CNT_W'(RD_LAT - 1)) begin
            r_mem_read <= 1'b0;
            if (r_we) begin
              r_mem_wdata <= w_merged;
              r_state     <= S_MERGE;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_load;
              r_state      <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_MERGE: begin
          r_mem_write <= 1'b1;
          r_cnt       <= '0;
          r_state     <= S_WR;
        end
        S_WR: begin
          if (r_cnt == CNT_W'(WR_LAT - 1)) begin
            r_mem_write  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_resp_valid <= 1'b0;
          r_resp_rdata <= 32'h0;
          r_mem_addr   <= 32'h0;
          r_mem_wdata  <= 32'h0;
          r_ready      <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-wide memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.RD_LAT(4), .WR_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  always @(posedge clk) if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[5:2]];

  logic        rec_rd   [1:20];
  logic        rec_wr   [1:20];
  logic        rec_rdy  [1:20];
  logic [31:0] rec_addr [1:20];
  logic [31:0] rec_wd   [1:20];
  int          resp_cyc;
  logic [31:0] resp_data;
  logic        resp_mis;

  // Issue one request and record per-cycle activity until the response (max 20 cycles).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    for (int k = 1; k <= 20; k++) begin
      rec_rd[k] = 1'b0; rec_wr[k] = 1'b0; rec_rdy[k] = 1'b0;
      rec_addr[k] = 32'h0; rec_wd[k] = 32'h0;
    end
    resp_cyc = 0; resp_data = 32'h0; resp_mis = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD; req_funct3 = 3'b111;
      end
      rec_rd[k] = mem_read; rec_wr[k] = mem_write; rec_rdy[k] = req_ready;
      rec_addr[k] = mem_addr; rec_wd[k] = mem_wdata;
      if (resp_valid) begin
        resp_cyc = k; resp_data = resp_rdata; resp_mis = resp_misaligned;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready_in_rst got=%b exp=0", req_ready);
    else n_pass++;
    rst = 1'b0;
    n_checks++;
    if ({req_ready, resp_valid, resp_misaligned, mem_read, mem_write} !== 5'b0 ||
        resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_outputs got=%b/%h/%h/%h exp=0",
               {req_ready, resp_valid, resp_misaligned, mem_read, mem_write},
               resp_rdata, mem_addr, mem_wdata);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready_after got=%b exp=1", req_ready);
    else n_pass++;
  endtask

  task automatic test_word_store();
    run_txn(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF);
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (rec_wr[k] !== 1'b1 || rec_rd[k] !== 1'b0 || rec_addr[k] !== 32'h0 ||
          rec_wd[k] !== 32'hDEAD_BEEF || rec_rdy[k] !== 1'b0)
        $display("FAIL sw_cycle%0d got wr=%b rd=%b addr=%h wd=%h rdy=%b exp wr=1 rd=0 addr=0 wd=deadbeef rdy=0",
                 k, rec_wr[k], rec_rd[k], rec_addr[k], rec_wd[k], rec_rdy[k]);
      else n_pass++;
    end
    n_checks++;
    if (resp_cyc !== 5 || resp_data !== 32'h0 || resp_mis !== 1'b0 || rec_rdy[5] !== 1'b0)
      $display("FAIL sw_resp got cyc=%0d data=%h mis=%b rdy=%b exp cyc=5 data=0 mis=0 rdy=0",
               resp_cyc, resp_data, resp_mis, rec_rdy[5]);
    else n_pass++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad  [5] = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h0};
    logic [31:0] exp [5] = '{32'hDEAD_BEEF, 32'hFFFF_FFBE, 32'h0000_00BE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, f3[i], ad[i], 32'h0);
      n_checks++;
      if (resp_cyc !== 5 || resp_data !== exp[i] || resp_mis !== 1'b0)
        $display("FAIL load%0d got cyc=%0d data=%h mis=%b exp cyc=5 data=%h mis=0",
                 i, resp_cyc, resp_data, resp_mis, exp[i]);
      else n_pass++;
      n_checks++;
      if (rec_rd[1] !== 1'b1 || rec_rd[4] !== 1'b1 || rec_rd[5] !== 1'b0 ||
          rec_wr[1] !== 1'b0 || rec_wr[4] !== 1'b0 || rec_addr[4] !== 32'h0)
        $display("FAIL load%0d_strobes got rd1=%b rd4=%b rd5=%b wr1=%b wr4=%b addr=%h exp 1 1 0 0 0 0",
                 i, rec_rd[1], rec_rd[4], rec_rd[5], rec_wr[1], rec_wr[4], rec_addr[4]);
      else n_pass++;
    end
  endtask

  task automatic test_subword_store();
    logic [2:0]  f3  [2] = '{3'b000, 3'b001};
    logic [31:0] ad  [2] = '{32'h2, 32'h0};
    logic [31:0] wd  [2] = '{32'hFFFF_FF11, 32'hFFFF_1234};
    logic [31:0] exp [2] = '{32'hDE11_BEEF, 32'hDEAD_1234};
    for (int i = 0; i < 2; i++) begin
      run_txn(1'b1, f3[i], ad[i], wd[i]);
      for (int k = 1; k <= 9; k++) begin
        n_checks++;
        if (rec_rd[k] !== (k <= 4) || rec_wr[k] !== (k >= 6) || rec_addr[k] !== 32'h0 ||
            (k >= 5 && rec_wd[k] !== exp[i]))
          $display("FAIL sub%0d_cycle%0d got rd=%b wr=%b addr=%h wd=%h exp rd=%b wr=%b addr=0 wd=%h",
                   i, k, rec_rd[k], rec_wr[k], rec_addr[k], rec_wd[k], (k <= 4), (k >= 6), exp[i]);
        else n_pass++;
      end
      n_checks++;
      if (resp_cyc !== 10 || resp_data !== 32'h0 || resp_mis !== 1'b0)
        $display("FAIL sub%0d_resp got cyc=%0d data=%h mis=%b exp cyc=10 data=0 mis=0",
                 i, resp_cyc, resp_data, resp_mis);
      else n_pass++;
      run_txn(1'b0, 3'b010, 32'h0, 32'h0);
      n_checks++;
      if (resp_data !== exp[i]) $display("FAIL sub%0d_readback got=%h exp=%h", i, resp_data, exp[i]);
      else n_pass++;
      run_txn(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_errors();
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3 [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] ad [4] = '{32'h2, 32'h1, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      run_txn(we[i], f3[i], ad[i], 32'h5555_5555);
      n_checks++;
      if (resp_cyc !== 1 || resp_mis !== 1'b1 || resp_data !== 32'h0 ||
          rec_rd[1] !== 1'b0 || rec_wr[1] !== 1'b0 || rec_addr[1] !== 32'h0)
        $display("FAIL err%0d got cyc=%0d mis=%b data=%h rd=%b wr=%b addr=%h exp cyc=1 mis=1 data=0 rd=0 wr=0 addr=0",
                 i, resp_cyc, resp_mis, resp_data, rec_rd[1], rec_wr[1], rec_addr[1]);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1)
        $display("FAIL err%0d_after got rd=%b wr=%b rv=%b rdy=%b exp 0 0 0 1",
                 i, mem_read, mem_write, resp_valid, req_ready);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h2; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1) $display("FAIL abort_pre got rd=%b exp=1", mem_read);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL abort_strobes got rd=%b wr=%b rv=%b rdy=%b exp 0 0 0 0",
               mem_read, mem_write, resp_valid, req_ready);
    else n_pass++;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid || mem_write || mem_read) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL abort_quiet got=%0d active cycles exp=0", seen);
    else n_pass++;
    run_txn(1'b0, 3'b010, 32'h0, 32'h0);
    n_checks++;
    if (resp_cyc !== 5 || resp_data !== 32'hDEAD_BEEF)
      $display("FAIL abort_readback got cyc=%0d data=%h exp cyc=5 data=deadbeef", resp_cyc, resp_data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic        rv  [1:14];
    logic        rdy [1:14];
    logic [31:0] rd  [1:14];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 7) req_valid = 1'b0;
      rv[k] = resp_valid; rdy[k] = req_ready; rd[k] = resp_rdata;
    end
    for (int k = 1; k <= 14; k++) begin
      n_checks++;
      if (rv[k] !== (k == 5 || k == 11) || rdy[k] !== (k == 6 || k >= 12) ||
          ((k == 5 || k == 11) && rd[k] !== 32'hDEAD_BEEF))
        $display("FAIL b2b_cycle%0d got rv=%b rdy=%b data=%h exp rv=%b rdy=%b",
                 k, rv[k], rdy[k], rd[k], (k == 5 || k == 11), (k == 6 || k >= 12));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_loads();
    test_subword_store();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
